// File: rtl/bawsss_pkg.sv
// rtl/bawsss_pkg.sv - shared types and constants for the data-memory controller
package bawsss_pkg;

  localparam int WORD_W          = 16;
  localparam int WAIT_STATES_DEF = 2;
  localparam int DEPTH_LOG2_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bawsss_sram.sv
// rtl/bawsss_sram.sv - word storage, combinational read, synchronous write
module bawsss_sram
  import bawsss_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  // No reset on the array: contents survive controller resets.
  logic [WORD_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Single write port, committed on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bawsss_dmem_ctrl.sv
// rtl/bawsss_dmem_ctrl.sv - CPU data-memory controller with fixed wait states
module bawsss_dmem_ctrl
  import bawsss_pkg::*;
#(
  parameter int WAIT_STATES = WAIT_STATES_DEF,
  parameter int DEPTH_LOG2  = DEPTH_LOG2_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [WORD_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              ready,
  output logic              err
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  state_t                state;
  state_t                state_next;
  logic [3:0]            cnt;
  logic [3:0]            cnt_next;
  logic                  accept;
  logic                  l_we;
  logic [WORD_W-1:0]     l_addr;
  logic [WORD_W-1:0]     l_wdata;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  fault;
  logic                  in_resp;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] index;
  logic [WORD_W-1:0]     mem_rdata;

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Capture the access only when it is accepted in IDLE; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (!reset) begin
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (accept) begin
      l_we    <= we;
      l_addr  <= addr;
      l_wdata <= wdata;
    end
  end

  // Next-state logic: IDLE -> WAIT (count down) -> RESP for one cycle -> IDLE.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = (WAIT_LOAD == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign index        = l_addr[DEPTH_LOG2:1];
  assign misaligned   = l_addr[0];
  assign out_of_range = (l_addr >> (DEPTH_LOG2 + 1)) != '0;
  assign fault        = misaligned | out_of_range;

  // Response outputs; gated by reset so an aborted RESP never strobes or writes.
  always_comb begin
    in_resp = (state == RESP) && reset;
    ready   = in_resp;
    err     = in_resp && fault;
    mem_we  = in_resp && l_we && !fault;
    rdata   = '0;
    if (in_resp && !fault && !l_we) begin
      rdata = mem_rdata;
    end
  end

  bawsss_sram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_sram (
    .clk   (clk),
    .we    (mem_we),
    .addr  (index),
    .wdata (l_wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_bawsss_dmem_ctrl.sv
// tb/tb_bawsss_dmem_ctrl.sv - scoreboard bench for the data-memory controller
module tb_bawsss_dmem_ctrl;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct {
    int          cyc;
    logic        err;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, we_a, req_b, we_b;
  logic [15:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [15:0] rdata_a, rdata_b;
  logic        ready_a, err_a, ready_b, err_b;

  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  bit   mon_on = 1'b0;
  exp_t exp_a[$];
  exp_t exp_b[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  bawsss_dmem_ctrl #(.WAIT_STATES(WS_A), .DEPTH_LOG2(8)) u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
    .wdata(wdata_a), .rdata(rdata_a), .ready(ready_a), .err(err_a)
  );

  bawsss_dmem_ctrl #(.WAIT_STATES(WS_B), .DEPTH_LOG2(8)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
    .wdata(wdata_b), .rdata(rdata_b), .ready(ready_b), .err(err_b)
  );

  // Monitor: pops an expectation on every ready strobe; otherwise outputs must be idle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      compared++;
      if (ready_a) begin
        if (exp_a.size() == 0) begin
          failed++;
          $display("FAIL a_unexpected_ready: cyc=%0d ready=1, want ready=0", cyc);
        end else begin
          e = exp_a.pop_front();
          if (cyc != e.cyc || err_a !== e.err || rdata_a !== e.rdata) begin
            failed++;
            $display("FAIL a_resp: cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h",
                     cyc, err_a, rdata_a, e.cyc, e.err, e.rdata);
          end
        end
      end else if (err_a !== 1'b0 || rdata_a !== 16'h0000) begin
        failed++;
        $display("FAIL a_idle_outputs: cyc=%0d err=%b rdata=%h, want err=0 rdata=0000",
                 cyc, err_a, rdata_a);
      end
      compared++;
      if (ready_b) begin
        if (exp_b.size() == 0) begin
          failed++;
          $display("FAIL b_unexpected_ready: cyc=%0d ready=1, want ready=0", cyc);
        end else begin
          e = exp_b.pop_front();
          if (cyc != e.cyc || err_b !== e.err || rdata_b !== e.rdata) begin
            failed++;
            $display("FAIL b_resp: cyc=%0d err=%b rdata=%h, want cyc=%0d err=%b rdata=%h",
                     cyc, err_b, rdata_b, e.cyc, e.err, e.rdata);
          end
        end
      end else if (err_b !== 1'b0 || rdata_b !== 16'h0000) begin
        failed++;
        $display("FAIL b_idle_outputs: cyc=%0d err=%b rdata=%h, want err=0 rdata=0000",
                 cyc, err_b, rdata_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
    compared++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  task automatic push_b(input int c, input logic e, input logic [15:0] d);
    exp_t x;
    x.cyc = c; x.err = e; x.rdata = d;
    exp_b.push_back(x);
  endtask

  // One access on DUT A; inputs are scrambled and req dropped while it is in flight.
  task automatic access_a(input logic w, input logic [15:0] a, input logic [15:0] d,
                          input logic e_err, input logic [15:0] e_rd);
    exp_t x;
    x.cyc = cyc + WS_A + 1; x.err = e_err; x.rdata = e_rd;
    exp_a.push_back(x);
    req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d;
    @(posedge clk); #1;
    req_a = 1'b0; we_a = ~w; addr_a = ~a; wdata_a = ~d;
    repeat (WS_A + 1) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    reset = 1'b0;
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_on = 1'b1;
    chk("reset_ready", {15'd0, ready_a}, 16'h0000);
    chk("reset_err", {15'd0, err_a}, 16'h0000);
    chk("reset_rdata", rdata_a, 16'h0000);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    access_a(1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0000);
    access_a(1'b0, 16'h0010, 16'h0000, 1'b0, 16'hBEEF);
    access_a(1'b1, 16'h0000, 16'h1111, 1'b0, 16'h0000);
    access_a(1'b0, 16'h0011, 16'h0000, 1'b1, 16'h0000);
    access_a(1'b1, 16'h0201, 16'hDEAD, 1'b1, 16'h0000);
    access_a(1'b1, 16'h0200, 16'hDEAD, 1'b1, 16'h0000);
    access_a(1'b0, 16'h8000, 16'h0000, 1'b1, 16'h0000);
    access_a(1'b0, 16'h0000, 16'h0000, 1'b0, 16'h1111);
    access_a(1'b1, 16'h01FE, 16'h7E7E, 1'b0, 16'h0000);
    access_a(1'b0, 16'h01FE, 16'h0000, 1'b0, 16'h7E7E);
    access_a(1'b1, 16'h0020, 16'h5555, 1'b0, 16'h0000);

    // Store aborted by reset in the second wait cycle: no strobe, no commit.
    req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0020; wdata_a = 16'h1234;
    @(posedge clk); #1;
    req_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_ready", {15'd0, ready_a}, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    access_a(1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5555);

    access_a(1'b1, 16'h00FE, 16'hA5A5, 1'b0, 16'h0000);
    access_a(1'b0, 16'h00FE, 16'h0000, 1'b0, 16'hA5A5);

    // DUT B, zero wait states, req held high: strobes every second cycle.
    c0 = cyc;
    push_b(c0 + 1, 1'b0, 16'h0000);
    push_b(c0 + 3, 1'b0, 16'h0A0A);
    push_b(c0 + 5, 1'b0, 16'h0000);
    push_b(c0 + 7, 1'b0, 16'h0B0B);
    req_b = 1'b1; we_b = 1'b1; addr_b = 16'h0004; wdata_b = 16'h0A0A;
    @(posedge clk); #1;
    we_b = 1'b0; addr_b = 16'h0004; wdata_b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    we_b = 1'b1; addr_b = 16'h0006; wdata_b = 16'h0B0B;
    repeat (2) @(posedge clk);
    #1;
    we_b = 1'b0; addr_b = 16'h0006; wdata_b = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    req_b = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    chk("a_queue_drained", 16'(exp_a.size()), 16'h0000);
    chk("b_queue_drained", 16'(exp_b.size()), 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
